// File: rtl/synth_cfg_regs.sv
// Configuration register bank for the synth core: pin writes are synchronised into
// shadow registers and committed to the active outputs on the core's frame boundary.
module synth_cfg_regs #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_strobe_pin,
  input  logic [3:0]  wr_addr_pin,
  input  logic [7:0]  wr_data_pin,
  input  logic        frame_tick,
  output logic [19:0] saw_period,
  output logic [7:0]  saw_oct,
  output logic [20:0] mod_period,
  output logic [11:0] mod_oct,
  output logic        mute,
  output logic        pending
);

  localparam int unsigned ADDR_W          = 4;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned OSC_PERIOD_BITS = 10;
  localparam int unsigned MOD_FIELD_BITS  = 5;
  localparam int unsigned OCT_BITS        = 4;

  typedef struct packed {
    logic [1:0][OSC_PERIOD_BITS-1:0] osc_per;
    logic [1:0][OCT_BITS-1:0]        osc_oct;
    logic [2:0][MOD_FIELD_BITS-1:0]  mod_fld;
    logic [2:0][OCT_BITS-1:0]        mod_oct;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    osc_per: {10'd512, 10'd512},
    osc_oct: {4'd4, 4'd4},
    mod_fld: '0,
    mod_oct: {4'hF, 4'hF, 4'hF}
  };

  // Decode one byte write from the register map into a configuration image.
  function automatic cfg_t apply_write(input cfg_t c, input logic [ADDR_W-1:0] a,
                                       input logic [DATA_W-1:0] d);
    cfg_t r;
    r = c;
    case (a)
      4'd0: r.osc_per[0][7:0] = d;
      4'd1: begin r.osc_per[0][9:8] = d[1:0]; r.osc_oct[0] = d[7:4]; end
      4'd2: r.osc_per[1][7:0] = d;
      4'd3: begin r.osc_per[1][9:8] = d[1:0]; r.osc_oct[1] = d[7:4]; end
      4'd4: r.mod_fld[0] = d[4:0];
      4'd5: r.mod_oct[0] = d[3:0];
      4'd6: r.mod_fld[1] = d[4:0];
      4'd7: r.mod_oct[1] = d[3:0];
      4'd8: r.mod_fld[2] = d[4:0];
      4'd9: r.mod_oct[2] = d[3:0];
      default: ;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0]             strobe_sync;
  logic [SYNC_STAGES-1:0]             sync_valid;
  logic [SYNC_STAGES-1:0][ADDR_W-1:0] addr_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync;
  logic                               strobe_d;

  // strobe_d is held high until the chain has refilled after reset, so a strobe
  // already high when reset drops cannot look like a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_sync <= '0;
      sync_valid  <= '0;
      addr_sync   <= '0;
      data_sync   <= '0;
      strobe_d    <= 1'b1;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], wr_strobe_pin};
      sync_valid  <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
      addr_sync   <= {addr_sync[SYNC_STAGES-2:0], wr_addr_pin};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], wr_data_pin};
      strobe_d    <= sync_valid[SYNC_STAGES-1] ? strobe_sync[SYNC_STAGES-1] : 1'b1;
    end
  end

  logic              wr_ev;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign wr_ev   = strobe_sync[SYNC_STAGES-1] & ~strobe_d;
  assign wr_addr = addr_sync[SYNC_STAGES-1];
  assign wr_data = data_sync[SYNC_STAGES-1];

  cfg_t shadow_q, shadow_d, active_q, active_d;
  logic immediate_q, immediate_d, mute_d, pending_d;

  // Commit uses the pre-write shadow; a coincident write lands afterwards and re-arms pending.
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    pending_d   = pending;
    mute_d      = mute;
    immediate_d = immediate_q;
    if (frame_tick && pending) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_ev) begin
      if (wr_addr <= 4'd9) begin
        shadow_d = apply_write(shadow_q, wr_addr, wr_data);
        if (immediate_q) active_d = apply_write(active_d, wr_addr, wr_data);
        else             pending_d = 1'b1;
      end else if (wr_addr == 4'd10) begin
        mute_d      = wr_data[0];
        immediate_d = wr_data[1];
      end else if (wr_addr == 4'd11 && !immediate_q) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q    <= CFG_RESET;
      active_q    <= CFG_RESET;
      mute        <= 1'b1;
      immediate_q <= 1'b0;
      pending     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      mute        <= mute_d;
      immediate_q <= immediate_d;
      pending     <= pending_d;
    end
  end

  assign saw_period = active_q.osc_per;
  assign saw_oct    = active_q.osc_oct;
  assign mod_oct    = active_q.mod_oct;
  assign mod_period = {2'b01, active_q.mod_fld[2], 2'b01, active_q.mod_fld[1],
                       2'b01, active_q.mod_fld[0]};

endmodule

// File: tb/tb_synth_cfg_regs.sv
// Self-checking bench for synth_cfg_regs: directed scenarios plus randomized writes
// checked against a register-image model of shadow/active contents.
module tb_synth_cfg_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_strobe_pin;
  logic [3:0]  wr_addr_pin;
  logic [7:0]  wr_data_pin;
  logic        frame_tick;
  logic [19:0] saw_period;
  logic [7:0]  saw_oct;
  logic [20:0] mod_period;
  logic [11:0] mod_oct;
  logic        mute;
  logic        pending;

  synth_cfg_regs #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .wr_strobe_pin(wr_strobe_pin), .wr_addr_pin(wr_addr_pin),
    .wr_data_pin(wr_data_pin), .frame_tick(frame_tick), .saw_period(saw_period),
    .saw_oct(saw_oct), .mod_period(mod_period), .mod_oct(mod_oct), .mute(mute),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: byte images of registers 0..9 as written, plus control/pending bits.
  bit [7:0] sh [10];
  bit [7:0] act[10];
  bit m_mute, m_imm, m_pend;

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 3)               sh[i] = 8'h42;
      else if (i == 5 || i == 7 || i == 9) sh[i] = 8'h0F;
      else                                 sh[i] = 8'h00;
    end
    act    = sh;
    m_mute = 1'b1;
    m_imm  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input bit tk, input bit ev, input bit [3:0] a, input bit [7:0] d);
    if (tk && m_pend) begin
      act    = sh;
      m_pend = 1'b0;
    end
    if (ev) begin
      if (a < 4'd10) begin
        sh[a] = d;
        if (m_imm) act[a] = d;
        else       m_pend = 1'b1;
      end else if (a == 4'd10) begin
        m_mute = d[0];
        m_imm  = d[1];
      end else if (a == 4'd11 && !m_imm) begin
        m_pend = 1'b1;
      end
    end
  endtask

  function automatic bit [62:0] exp_vec();
    bit [9:0] p0, p1;
    p0 = {act[1][1:0], act[0]};
    p1 = {act[3][1:0], act[2]};
    return {p1, p0, act[3][7:4], act[1][7:4],
            2'b01, act[8][4:0], 2'b01, act[6][4:0], 2'b01, act[4][4:0],
            act[9][3:0], act[7][3:0], act[5][3:0], m_mute, m_pend};
  endfunction

  function automatic bit [62:0] got_vec();
    return {saw_period, saw_oct, mod_period, mod_oct, mute, pending};
  endfunction

  // One clock; ev tells the model that a write lands on this edge.
  task automatic cyc(input bit tk, input bit ev, input bit [3:0] a, input bit [7:0] d);
    frame_tick = tk;
    @(posedge clk);
    model_edge(tk, ev, a, d);
    #1;
    frame_tick = 1'b0;
  endtask

  // The write lands on the third edge after the pin strobe rises.
  task automatic write_land(input bit [3:0] a, input bit [7:0] d, input bit tk);
    wr_addr_pin = a;
    wr_data_pin = d;
    cyc(1'b0, 1'b0, a, d);
    wr_strobe_pin = 1'b1;
    cyc(1'b0, 1'b0, a, d);
    cyc(1'b0, 1'b0, a, d);
    cyc(tk, 1'b1, a, d);
  endtask

  task automatic write_release();
    cyc(1'b0, 1'b0, 4'd0, 8'd0);
    wr_strobe_pin = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic do_write(input bit [3:0] a, input bit [7:0] d, input bit tk);
    write_land(a, d, tk);
    write_release();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 4'd0, 8'd0);
    model_reset();
    reset = 1'b0;
    repeat (20) cyc(1'b0, 1'b0, 4'd0, 8'd0);
    checks++; if (saw_period !== {10'd512, 10'd512}) begin failures++; $display("FAIL reset_saw_period got=%h exp=%h", saw_period, {10'd512, 10'd512}); end
    checks++; if (saw_oct !== 8'h44) begin failures++; $display("FAIL reset_saw_oct got=%h exp=44", saw_oct); end
    checks++; if (mod_period !== {7'h20, 7'h20, 7'h20}) begin failures++; $display("FAIL reset_mod_period got=%h exp=%h", mod_period, {7'h20, 7'h20, 7'h20}); end
    checks++; if (mod_oct !== 12'hFFF) begin failures++; $display("FAIL reset_mod_oct got=%h exp=fff", mod_oct); end
    checks++; if (mute !== 1'b1) begin failures++; $display("FAIL reset_mute got=%b exp=1", mute); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL reset_model got=%h exp=%h", got_vec(), exp_vec()); end
  endtask

  task automatic test_commit();
    do_write(4'd0, 8'h34, 1'b0);
    do_write(4'd1, 8'h52, 1'b0);
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL commit_pending_set got=%b exp=1", pending); end
    checks++; if (saw_period[9:0] !== 10'd512) begin failures++; $display("FAIL commit_not_early got=%h exp=200", saw_period[9:0]); end
    cyc(1'b1, 1'b0, 4'd0, 8'd0);
    checks++; if (saw_period[9:0] !== 10'h234) begin failures++; $display("FAIL commit_period got=%h exp=234", saw_period[9:0]); end
    checks++; if (saw_oct[3:0] !== 4'd5) begin failures++; $display("FAIL commit_oct got=%h exp=5", saw_oct[3:0]); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL commit_pending_clr got=%b exp=0", pending); end
    checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL commit_model got=%h exp=%h", got_vec(), exp_vec()); end
  endtask

  task automatic test_latency();
    do_write(4'd10, 8'h02, 1'b0);
    wr_addr_pin = 4'd4;
    wr_data_pin = 8'h1F;
    cyc(1'b0, 1'b0, 4'd0, 8'd0);
    wr_strobe_pin = 1'b1;
    for (int e = 0; e < 3; e++) begin
      cyc(1'b0, e == 2, 4'd4, 8'h1F);
      checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL latency_edge%0d got=%h exp=%h", e, got_vec(), exp_vec()); end
    end
    checks++; if (mod_period[6:0] !== 7'h3F) begin failures++; $display("FAIL latency_value got=%h exp=3f", mod_period[6:0]); end
    wr_data_pin = 8'h05;
    for (int e = 0; e < 4; e++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'd0);
      checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL latency_no_rewrite%0d got=%h exp=%h", e, got_vec(), exp_vec()); end
    end
    wr_strobe_pin = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 4'd0, 8'd0);
    do_write(4'd10, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 4'd0, 8'd0);
    do_write(4'd0, 8'hA5, 1'b0);
    write_land(4'd6, 8'h0C, 1'b1);
    checks++; if (saw_period[7:0] !== 8'hA5) begin failures++; $display("FAIL coincide_commit got=%h exp=a5", saw_period[7:0]); end
    checks++; if (mod_period[13:7] !== 7'h20) begin failures++; $display("FAIL coincide_mod1_held got=%h exp=20", mod_period[13:7]); end
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL coincide_pending got=%b exp=1", pending); end
    write_release();
    cyc(1'b1, 1'b0, 4'd0, 8'd0);
    checks++; if (mod_period[13:7] !== 7'h2C) begin failures++; $display("FAIL coincide_mod1_next got=%h exp=2c", mod_period[13:7]); end
    checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL coincide_model got=%h exp=%h", got_vec(), exp_vec()); end
  endtask

  task automatic test_immediate();
    cyc(1'b1, 1'b0, 4'd0, 8'd0);
    do_write(4'd10, 8'h02, 1'b0);
    write_land(4'd8, 8'h07, 1'b0);
    checks++; if (mod_period[20:14] !== 7'h27) begin failures++; $display("FAIL imm_mod2 got=%h exp=27", mod_period[20:14]); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL imm_pending got=%b exp=0", pending); end
    checks++; if (mute !== 1'b0) begin failures++; $display("FAIL imm_mute got=%b exp=0", mute); end
    write_release();
    do_write(4'd15, 8'hFF, 1'b0);
    checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL imm_addr15 got=%h exp=%h", got_vec(), exp_vec()); end
    do_write(4'd10, 8'h00, 1'b0);
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL imm_clear_no_pending got=%b exp=0", pending); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit [3:0] a;
      bit [7:0] d;
      bit       tk;
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      tk = ($urandom_range(0, 3) == 0);
      do_write(a, d, tk);
      checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL random_write%0d a=%0d got=%h exp=%h", n, a, got_vec(), exp_vec()); end
      if ($urandom_range(0, 2) == 0) begin
        cyc(1'b1, 1'b0, 4'd0, 8'd0);
        checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL random_tick%0d got=%h exp=%h", n, got_vec(), exp_vec()); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(4'd10, 8'h00, 1'b0);
    do_write(4'd2, 8'h11, 1'b0);
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rstmid_pre_pending got=%b exp=1", pending); end
    wr_addr_pin   = 4'd0;
    wr_data_pin   = 8'h99;
    wr_strobe_pin = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 8'd0);
    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 4'd0, 8'd0);
    model_reset();
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'd0);
      checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL rstmid_held%0d got=%h exp=%h", e, got_vec(), exp_vec()); end
    end
    checks++; if (mute !== 1'b1 || pending !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b%b exp=10", mute, pending); end
    wr_strobe_pin = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 4'd0, 8'd0);
    do_write(4'd0, 8'h99, 1'b0);
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rstmid_rewrite_pending got=%b exp=1", pending); end
    cyc(1'b1, 1'b0, 4'd0, 8'd0);
    checks++; if (saw_period[9:0] !== 10'h299) begin failures++; $display("FAIL rstmid_rewrite got=%h exp=299", saw_period[9:0]); end
    checks++; if (got_vec() !== exp_vec()) begin failures++; $display("FAIL rstmid_model got=%h exp=%h", got_vec(), exp_vec()); end
  endtask

  initial begin
    reset         = 1'b1;
    wr_strobe_pin = 1'b0;
    wr_addr_pin   = 4'd0;
    wr_data_pin   = 8'd0;
    frame_tick    = 1'b0;
    model_reset();
    test_reset();
    test_commit();
    test_latency();
    test_back_to_back();
    test_immediate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
